// File: rtl/multi_debounce.sv
// Multi-channel push-button / switch debouncer with press, release,
// long-press and auto-repeat ticks.
//
// Ports:
//   clk_i          system clock (single domain)
//   rst_i          asynchronous, active-high reset
//   sw_i           raw asynchronous inputs, one bit per channel
//   db_level_o     debounced logical level per channel (1 = pressed)
//   press_tick_o   one-cycle pulse when a press commits
//   release_tick_o one-cycle pulse when a release commits
//   long_tick_o    one-cycle pulse on long press and on each auto-repeat
//   any_press_o    OR of all press_tick_o bits, same cycle
module multi_debounce #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned CNT_W         = 21,
    parameter int unsigned ACTIVE_LOW    = 0,
    parameter int unsigned HOLD_W        = 26,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CHANNELS-1:0] sw_i,
    output logic [CHANNELS-1:0] db_level_o,
    output logic [CHANNELS-1:0] press_tick_o,
    output logic [CHANNELS-1:0] release_tick_o,
    output logic [CHANNELS-1:0] long_tick_o,
    output logic                any_press_o
);

    typedef enum logic [1:0] {
        ST_ZERO  = 2'd0,
        ST_WAIT1 = 2'd1,
        ST_ONE   = 2'd2,
        ST_WAIT0 = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0]  CNT_M      = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_TGT   = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_RLD   = HOLD_W'(HOLD_CYCLES - REPEAT_CYCLES);
    localparam logic              INV_LEVEL  = 1'(ACTIVE_LOW);

    logic [CHANNELS-1:0] press_d_all;
    logic                any_press_q;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        logic              sync1_q, sync2_q;
        state_e            state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              rel_q, rel_d;
        logic              long_q, long_d;
        logic              hold_run;

        // Synchroniser (in logical polarity), FSM, timers and tick registers
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                state_q <= ST_ZERO;
                cnt_q   <= '0;
                hold_q  <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
            end else begin
                sync1_q <= sw_i[g] ^ INV_LEVEL;
                sync2_q <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
                hold_q  <= hold_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                long_q  <= long_d;
            end
        end

        // Debounce next-state, hold timer and tick generation
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            hold_d   = hold_q;
            press_d  = 1'b0;
            rel_d    = 1'b0;
            long_d   = 1'b0;
            hold_run = 1'b0;

            case (state_q)
                ST_ZERO: begin
                    hold_d = '0;
                    if (sync2_q) begin
                        state_d = ST_WAIT1;
                        cnt_d   = CNT_M;
                    end
                end
                ST_WAIT1: begin
                    if (!sync2_q) begin
                        state_d = ST_ZERO;
                    end else if (cnt_q > CNT_ONE) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        state_d = ST_ONE;
                        press_d = 1'b1;
                        hold_d  = '0;
                    end
                end
                ST_ONE: begin
                    hold_run = 1'b1;
                    if (!sync2_q) begin
                        state_d = ST_WAIT0;
                        cnt_d   = CNT_M;
                    end
                end
                ST_WAIT0: begin
                    if (sync2_q) begin
                        state_d  = ST_ONE;
                        hold_run = 1'b1;
                    end else if (cnt_q > CNT_ONE) begin
                        cnt_d    = cnt_q - CNT_ONE;
                        hold_run = 1'b1;
                    end else begin
                        // Release wins over a long tick due in this cycle
                        state_d = ST_ZERO;
                        rel_d   = 1'b1;
                        hold_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_ZERO;
                    cnt_d   = '0;
                    hold_d  = '0;
                end
            endcase

            // Hold timer: at target, tick and reload; sitting at target means
            // repeat is disabled and the timer stays frozen until release.
            if (hold_run) begin
                if (hold_q == HOLD_TGT) begin
                    hold_d = hold_q;
                end else if (hold_q == HOLD_LAST) begin
                    long_d = 1'b1;
                    hold_d = HOLD_RLD;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            level_d = (state_d == ST_ONE) || (state_d == ST_WAIT0);
        end

        assign press_d_all[g]    = press_d;
        assign db_level_o[g]     = level_q;
        assign press_tick_o[g]   = press_q;
        assign release_tick_o[g] = rel_q;
        assign long_tick_o[g]    = long_q;
    end

    // Aggregate press indicator, registered alongside the per-channel ticks
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= |press_d_all;
        end
    end

    assign any_press_o = any_press_q;

endmodule

// File: doc/multi_debounce.md
# multi_debounce

Parametrised multi-channel debouncer for push-buttons and switches, replacing the single-channel debouncer in the user-input path of the game. Each channel gets a two-flop synchroniser, a selectable active level, a four-state debounce FSM with a configurable stability window, and press/release ticks. A hold timer per channel adds long-press and auto-repeat ticks that the game logic consumes directly.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `CNT_W`, 21: stability counter width; window M = 2^CNT_W − 1 cycles (≈42 ms at 50 MHz).
- `ACTIVE_LOW`, 0: 1 = raw input asserted when 0 (pull-up buttons); applied to all channels.
- `HOLD_W`, 26: hold timer width; must represent max(HOLD_CYCLES, REPEAT_CYCLES).
- `HOLD_CYCLES`, 50_000_000: cycles from press_tick to first long_tick (≥1).
- `REPEAT_CYCLES`, 10_000_000: cycles between subsequent long_ticks; 0 = single long_tick only.
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `sw` in CHANNELS: raw, asynchronous inputs.
- `db_level` out CHANNELS: debounced logical level (1 = pressed).
- `press_tick` out CHANNELS: one-cycle pulse on committed press.
- `release_tick` out CHANNELS: one-cycle pulse on committed release.
- `long_tick` out CHANNELS: one-cycle pulse on long press / auto-repeat.
- `any_press` out 1: OR of all press_tick bits, same cycle.

## Operation
- Per channel: s = 2-flop synchronised (sw XOR ACTIVE_LOW). All outputs registered.
- FSM states: ZERO, WAIT1, ONE, WAIT0; counter cnt[CNT_W-1:0].
- ZERO: db_level=0. If s=1 → WAIT1, cnt ← M.
- WAIT1: db_level=0. s=0 → ZERO (bounce, no tick). s=1 and cnt>1 → cnt−1. s=1 and cnt=1 → ONE, press_tick=1 next cycle.
- ONE: db_level=1. If s=0 → WAIT0, cnt ← M.
- WAIT0: db_level=1. s=1 → ONE (no tick, hold timer unaffected). s=0 and cnt>1 → cnt−1. s=0 and cnt=1 → ZERO, release_tick=1 next cycle.
- Illegal state → ZERO.
- Hold timer h[HOLD_W-1:0]: cleared to 0 in the press_tick cycle; increments every cycle while in ONE or WAIT0; cleared on entry to ZERO.
- long_tick fires when h reaches HOLD_CYCLES, then h reloads to HOLD_CYCLES − REPEAT_CYCLES so ticks repeat every REPEAT_CYCLES. If REPEAT_CYCLES=0, h freezes at HOLD_CYCLES; no further ticks until the next press.
- Channels are fully independent; simultaneous events on several channels all produce their own ticks in the same cycle.
- Ticks never overlap on one channel: press_tick, long_tick and release_tick are mutually exclusive per channel per cycle. A release committing in the same cycle h would reach its target suppresses long_tick.

## Timing
- Reset (async): all FSMs ZERO, cnt=0, h=0, synchroniser flops at logical 0 (raw inactive level). db_level, press_tick, release_tick, long_tick and any_press are all 0.
- Synchroniser latency: 2 cycles from sw change to s.
- Press latency: s first 1 at edge t → WAIT1 at t+1 → commit at t+M → db_level=1 and press_tick=1 at t+M+1. Total M+3 edges from the first edge sampling raw asserted.
- Release latency: symmetric, M+3 edges.
- Any glitch in s during WAITx restarts the whole window from M on the next qualifying edge.
- long_tick asserts HOLD_CYCLES cycles after the press_tick cycle, then every REPEAT_CYCLES cycles.
- Reset mid-window or mid-hold aborts immediately. No ticks are emitted on reset assertion or release.

## Test plan
- Clean press, CNT_W=4 (M=15), CHANNELS=4: sw[0] held 1 → press_tick[0] for exactly 1 cycle at edge 18, db_level[0]=1 from edge 18, any_press=1 in the same cycle; other channels stay 0.
- Bounce: sw[1] toggles every 5 cycles ×6, then stable 1 → no ticks during bouncing; one press_tick 18 edges after the last rising edge. Same on release → single release_tick.
- Long press/repeat, HOLD_CYCLES=40, REPEAT_CYCLES=10: hold sw[2] for 100 cycles after press_tick → long_tick at +40, +50, +60, … +100. Release → release_tick; long_tick stops; h returns to 0.
- REPEAT_CYCLES=0, ACTIVE_LOW=1: drive sw[3]=0 for 120 cycles → press_tick once, long_tick exactly once at +40; raw 1 → release_tick.
- Simultaneous events: sw[0] rises while sw[1] falls on the same edge → press_tick[0] and release_tick[1] in the same cycle.
- Reset mid-operation: assert rst during WAIT1 and again 20 cycles into hold → all outputs 0 immediately (asynchronous); no tick after deassertion unless the input stays asserted for a fresh M+3 edges.
